shift_acc: RTL and testbench

Bit-serial shift-and-accumulate stage of the DCIM macro, directly downstream of the global controller and the column adder tree. The controller starts an operation and then sequences input bit-planes. The adder tree delivers one signed partial sum per plane, MSB-plane first. This block weights each partial sum by its bit position, applies two's-complement sign handling on the MSB plane, and hands the finished MAC result to the readout path through a one-entry valid/ready output buffer.

---
 rtl/dcim_pkg.sv | 16 +
 rtl/acc_obuf.sv | 65 ++++++
 rtl/shift_acc.sv | 118 +++++++++++
 tb/tb_shift_acc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_pkg.sv
// Shared DCIM definitions: plane counts, shift-accumulate state encoding
// and the default datapath widths used by the macro top.
package dcim_pkg;

  localparam int PLANES_12      = 12;
  localparam int PLANES_24      = 24;
  localparam int CNT_WIDTH      = 5;
  localparam int PSUM_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 48;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/acc_obuf.sv
// One-entry valid/ready result buffer; a result arriving while the entry is
// full and not being popped is dropped and flagged on the sticky drop_err.
module acc_obuf
  import dcim_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [ACC_WIDTH-1:0] push_data,
  input  logic                 out_ready,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 drop_err
);

  logic                 valid_r;
  logic [ACC_WIDTH-1:0] data_r;
  logic                 drop_err_r;
  logic                 load_s;
  logic                 pop_s;
  logic                 drop_s;

  // Push/pop/drop decode; a pop in the same cycle frees the slot for the push.
  always_comb begin
    pop_s  = valid_r & out_ready;
    load_s = 1'b0;
    drop_s = 1'b0;
    if (push) begin
      load_s = ~valid_r | out_ready;
      drop_s = valid_r & ~out_ready;
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Buffer entry and sticky error flag; a new drop wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      data_r     <= {ACC_WIDTH{1'b0}};
      drop_err_r <= 1'b0;
    end else begin
      if (load_s) begin
        valid_r <= 1'b1;
        data_r  <= push_data;
      end else if (pop_s) begin
        valid_r <= 1'b0;
      end
      if (drop_s) begin
        drop_err_r <= 1'b1;
      end else if (err_clr) begin
        drop_err_r <= 1'b0;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign drop_err  = drop_err_r;

endmodule

// File: rtl/shift_acc.sv
// Bit-serial shift-and-accumulate: weights MSB-first plane partial sums by bit
// position, negates the MSB plane for signed inputs, and buffers the result.
module shift_acc
  import dcim_pkg::*;
#(
  parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
  parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
  parameter int INWIDTH_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INWIDTH_WIDTH-1:0] inwidth,
  input  logic                     in_signed,
  input  logic                     start_acc,
  input  logic                     psum_valid,
  input  logic [PSUM_WIDTH-1:0]    psum,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic                     out_valid,
  output logic [ACC_WIDTH-1:0]     out_data,
  output logic                     busy,
  output logic                     drop_err
);

  acc_state_e           state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0] plane_cnt_r;
  logic [CNT_WIDTH-1:0] nplanes_r;

  logic [ACC_WIDTH-1:0] psum_ext_s;
  logic [ACC_WIDTH-1:0] first_s;
  logic [ACC_WIDTH-1:0] acc_next_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic [CNT_WIDTH-1:0] nplanes_sel_s;
  logic                 start_s;
  logic                 done_s;

  // Datapath terms: sign-extended plane, MSB-plane seed, shift-add and completion.
  always_comb begin
    psum_ext_s = {{(ACC_WIDTH-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};
    if (in_signed) begin
      first_s = {ACC_WIDTH{1'b0}} - psum_ext_s;
    end else begin
      first_s = psum_ext_s;
    end
    if (inwidth != {INWIDTH_WIDTH{1'b0}}) begin
      nplanes_sel_s = CNT_WIDTH'(PLANES_24);
    end else begin
      nplanes_sel_s = CNT_WIDTH'(PLANES_12);
    end
    acc_next_s = (acc_r << 1) + psum_ext_s;
    cnt_inc_s  = plane_cnt_r + 5'd1;
    start_s    = start_acc & psum_valid;
    done_s     = 1'b0;
    case (state_r)
      ACC:     done_s = psum_valid & ~start_acc & (cnt_inc_s == nplanes_r);
      IDLE:    done_s = 1'b0;
      default: done_s = 1'b0;
    endcase
  end

  // FSM, plane counter and accumulator; a start in ACC aborts and reseeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_WIDTH{1'b0}};
      plane_cnt_r <= 5'd0;
      nplanes_r   <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= ACC;
            acc_r       <= first_s;
            plane_cnt_r <= 5'd1;
            nplanes_r   <= nplanes_sel_s;
          end
        end
        ACC: begin
          if (start_s) begin
            acc_r       <= first_s;
            plane_cnt_r <= 5'd1;
            nplanes_r   <= nplanes_sel_s;
          end else if (psum_valid) begin
            acc_r <= acc_next_s;
            if (done_s) begin
              state_r     <= IDLE;
              plane_cnt_r <= 5'd0;
            end else begin
              plane_cnt_r <= cnt_inc_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          plane_cnt_r <= 5'd0;
        end
      endcase
    end
  end

  assign busy = (state_r == ACC);

  acc_obuf #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (done_s),
    .push_data (acc_next_s),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .drop_err  (drop_err)
  );

endmodule

// File: tb/tb_shift_acc.sv
// Directed bench for shift_acc: hand-computed MAC results, latency, drop
// handling, restart, plane gaps and asynchronous reset.
module tb_shift_acc;

  logic        clk;
  logic        rst_n;
  logic [0:0]  inwidth;
  logic        in_signed;
  logic        start_acc;
  logic        psum_valid;
  logic [15:0] psum;
  logic        out_ready;
  logic        err_clr;
  logic        out_valid;
  logic [47:0] out_data;
  logic        busy;
  logic        drop_err;

  int n_cmp;
  int n_err;
  logic signed [15:0] vec [24];
  logic ready_last;
  logic clr_last;
  logic signed [47:0] exp_v;

  shift_acc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inwidth    (inwidth),
    .in_signed  (in_signed),
    .start_acc  (start_acc),
    .psum_valid (psum_valid),
    .psum       (psum),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 24; i++) vec[i] = 16'sd0;
  endtask

  // Drives n planes from vec; gaps inserts idle cycles between some planes.
  task automatic run_op(input int n, input logic iw, input logic sg, input logic gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        for (int g = 0; g <= (i % 2); g++) tick();
      end
      start_acc  = (i == 0);
      psum_valid = 1'b1;
      psum       = vec[i];
      inwidth    = iw;
      in_signed  = sg;
      if (i == n - 1) begin
        out_ready = ready_last;
        err_clr   = clr_last;
      end
      tick();
      start_acc  = 1'b0;
      psum_valid = 1'b0;
      out_ready  = 1'b0;
      err_clr    = 1'b0;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0 || out_data !== 48'd0) begin
      n_err++;
      $display("FAIL reset: valid=%b busy=%b drop=%b data=%0d, required all 0",
               out_valid, busy, drop_err, out_data);
    end
  endtask

  task automatic test_unsigned12();
    for (int i = 0; i < 12; i++) begin
      start_acc = (i == 0); psum_valid = 1'b1; psum = 16'sd1;
      inwidth = 1'b0; in_signed = 1'b0;
      tick();
      start_acc = 1'b0; psum_valid = 1'b0;
      if (i == 10) begin
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL early_valid: valid=%b busy=%b, required 0/1", out_valid, busy);
        end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 48'd4095 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL unsigned12: valid=%b data=%0d busy=%b, required 1/4095/0",
               out_valid, out_data, busy);
    end
    pop();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pop: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_signed12();
    clear_vec(); vec[0] = 16'sd1;
    run_op(12, 1'b0, 1'b1, 1'b0);
    exp_v = -48'sd2048;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_err++;
      $display("FAIL signed_msb: valid=%b data=%0d, required 1/%0d", out_valid, $signed(out_data), exp_v);
    end
    pop();
    clear_vec(); vec[0] = -16'sd3; vec[11] = 16'sd5;
    run_op(12, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_data !== 48'd6149) begin
      n_err++;
      $display("FAIL signed_mix: data=%0d, required 6149", $signed(out_data));
    end
    pop();
  endtask

  task automatic test_width24();
    for (int i = 0; i < 24; i++) vec[i] = -16'sd1;
    run_op(24, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 48'd1) begin
      n_err++;
      $display("FAIL signed24: valid=%b data=%0d, required 1/1", out_valid, $signed(out_data));
    end
    pop();
    for (int i = 0; i < 24; i++) vec[i] = 16'sd1;
    run_op(24, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (out_data !== 48'd16777215) begin
      n_err++;
      $display("FAIL unsigned24: data=%0d, required 16777215", out_data);
    end
    pop();
  endtask

  task automatic test_stall_drop();
    clear_vec(); vec[11] = 16'sd7;
    run_op(12, 1'b0, 1'b0, 1'b0);
    clear_vec(); vec[11] = 16'sd9;
    run_op(12, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 48'd7 || drop_err !== 1'b1) begin
      n_err++;
      $display("FAIL drop: valid=%b data=%0d drop=%b, required 1/7/1", out_valid, out_data, drop_err);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_cmp++;
    if (drop_err !== 1'b0 || out_data !== 48'd7) begin
      n_err++;
      $display("FAIL err_clr: drop=%b data=%0d, required 0/7", drop_err, out_data);
    end
    clear_vec(); vec[11] = 16'sd3;
    ready_last = 1'b1;
    run_op(12, 1'b0, 1'b0, 1'b0);
    ready_last = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 48'd3 || drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL pop_push: valid=%b data=%0d drop=%b, required 1/3/0", out_valid, out_data, drop_err);
    end
    clear_vec(); vec[11] = 16'sd4;
    clr_last = 1'b1;
    run_op(12, 1'b0, 1'b0, 1'b0);
    clr_last = 1'b0;
    n_cmp++;
    if (drop_err !== 1'b1 || out_data !== 48'd3) begin
      n_err++;
      $display("FAIL set_wins: drop=%b data=%0d, required 1/3", drop_err, out_data);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    pop();
  endtask

  task automatic test_restart();
    for (int i = 0; i < 24; i++) vec[i] = 16'sd100;
    run_op(5, 1'b0, 1'b0, 1'b0);
    clear_vec(); vec[10] = 16'sd1; vec[11] = 16'sd2;
    run_op(12, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 48'd4 || drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL restart: valid=%b data=%0d drop=%b, required 1/4/0", out_valid, out_data, drop_err);
    end
    pop();
  endtask

  task automatic test_gaps();
    clear_vec(); vec[0] = 16'sd1; vec[5] = 16'sd3; vec[11] = -16'sd2;
    exp_v = -48'sd1858;
    run_op(12, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_data !== exp_v) begin
      n_err++;
      $display("FAIL b2b_ref: data=%0d, required %0d", $signed(out_data), exp_v);
    end
    pop();
    start_acc = 1'b1; psum_valid = 1'b0; psum = 16'sd77; tick(); start_acc = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_no_valid: busy=%b, required 0", busy);
    end
    run_op(12, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_err++;
      $display("FAIL gaps: valid=%b data=%0d, required 1/%0d", out_valid, $signed(out_data), exp_v);
    end
    pop();
  endtask

  task automatic test_async_reset();
    clear_vec(); vec[11] = 16'sd5;
    run_op(12, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) vec[i] = 16'sd1;
    run_op(4, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 48'd0) begin
      n_err++;
      $display("FAIL async_rst: busy=%b valid=%b data=%0d, required 0/0/0", busy, out_valid, out_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_op(12, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 48'd4095) begin
      n_err++;
      $display("FAIL post_rst: valid=%b data=%0d, required 1/4095", out_valid, out_data);
    end
    pop();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; inwidth = 1'b0; in_signed = 1'b0; start_acc = 1'b0;
    psum_valid = 1'b0; psum = 16'd0; out_ready = 1'b0; err_clr = 1'b0;
    ready_last = 1'b0; clr_last = 1'b0;
    clear_vec();
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_unsigned12();
    test_signed12();
    test_width24();
    test_stall_drop();
    test_restart();
    test_gaps();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
